// File: rtl/count_tracker_pkg.sv
// Shared types for the counter-stream monitor.
// COUNT_TRACKER_TIMESTAMP_EN adds an 8-bit sample index to each record.
package count_tracker_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'b00,
    EVT_WRAP = 2'b01,
    EVT_SKIP = 2'b10
  } evt_type_e;

  typedef struct packed {
    evt_type_e   typ;
    logic [3:0]  val;
`ifdef COUNT_TRACKER_TIMESTAMP_EN
    logic [7:0]  ts;
`endif
  } evt_rec_t;

  localparam logic [3:0] CNT_MAX_VAL = 4'hF;

endpackage

// File: rtl/count_tracker_fifo.sv
// Synchronous event-record FIFO, flushed on rst.
// Pointers carry an extra wrap bit to tell full from empty.
module count_tracker_fifo
  import count_tracker_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = evt_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wp, rp;
  T            mem [DEPTH];
  logic        wr, rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // a full FIFO still takes a push when the head leaves this cycle
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);

  assign dout = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + PTR_ONE;
      end
      if (rd)
        rp <= rp + PTR_ONE;
    end
  end

endmodule

// File: rtl/count_tracker.sv
// Monitors a 4-bit counter stream; queues WRAP/SKIP events.
// COUNT_TRACKER_TIMESTAMP_EN adds out_ts and a sample index.
module count_tracker
  import count_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [3:0]       out_val,
`ifdef COUNT_TRACKER_TIMESTAMP_EN
  output logic [7:0]       out_ts,
`endif
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             overflow
);

  typedef enum logic {
    EMPTY_HIST,
    TRACK
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic       evt;
  evt_type_e  evt_t;
  evt_rec_t   rec, head;
  logic       full, empty, pop;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    evt     = 1'b0;
    evt_t   = EVT_NONE;
    if (in_valid) begin
      prev_d  = in_val;
      state_d = TRACK;
      if (state_q == TRACK) begin
        unique case (1'b1)
          (prev_q == CNT_MAX_VAL &&
           in_val == 4'h0): begin
            evt   = 1'b1;
            evt_t = EVT_WRAP;
          end
          (prev_q != CNT_MAX_VAL &&
           in_val == prev_q + 4'd1): begin
            evt = 1'b0;
          end
          (in_val == prev_q): begin
            evt = 1'b0;
          end
          default: begin
            evt   = 1'b1;
            evt_t = EVT_SKIP;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY_HIST;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

`ifdef COUNT_TRACKER_TIMESTAMP_EN
  logic [7:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst)
      idx_q <= '0;
    else if (in_valid)
      idx_q <= idx_q + 8'd1;
  end

  assign rec = '{typ: evt_t, val: in_val, ts: idx_q};
  assign out_ts = head.ts;
`else
  assign rec = '{typ: evt_t, val: in_val};
`endif

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_type  = head.typ;
  assign out_val   = head.val;

  count_tracker_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // totals count every event, including ones the FIFO drops
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt <= '0;
      skip_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (evt && evt_t == EVT_WRAP && wrap_cnt != '1)
        wrap_cnt <= wrap_cnt + CNT_ONE;
      if (evt && evt_t == EVT_SKIP && skip_cnt != '1)
        skip_cnt <= skip_cnt + CNT_ONE;
      if (evt && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker: vector table plus
// hand-written sequences for FIFO full, saturation, reset.
module tb_count_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_val = '0;
  logic       out_ready = 1'b0;

  logic       out_valid;
  logic [1:0] out_type;
  logic [3:0] out_val;
  logic [7:0] wrap_cnt, skip_cnt;
  logic       overflow;

  logic       s_valid;
  logic [1:0] s_type;
  logic [3:0] s_val;
  logic [1:0] s_wrap, s_skip;
  logic       s_ovf;

`ifdef COUNT_TRACKER_TIMESTAMP_EN
  logic [7:0] out_ts, s_ts;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_tracker #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_val   (out_val),
`ifdef COUNT_TRACKER_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .wrap_cnt  (wrap_cnt),
    .skip_cnt  (skip_cnt),
    .overflow  (overflow)
  );

  count_tracker #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_val    (in_val),
    .out_valid (s_valid),
    .out_ready (out_ready),
    .out_type  (s_type),
    .out_val   (s_val),
`ifdef COUNT_TRACKER_TIMESTAMP_EN
    .out_ts    (s_ts),
`endif
    .wrap_cnt  (s_wrap),
    .skip_cnt  (s_skip),
    .overflow  (s_ovf)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       r;
    logic       ev;
    logic [1:0] et;
    logic [3:0] ed;
    int         ew;
    int         es;
    logic       eo;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [3:0] d,
                      input logic r);
    in_valid  = v;
    in_val    = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input logic [3:0] v, input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_type"}, 32'(out_type), 2);
    chk({nm, "_val"}, 32'(out_val), 32'(v));
    step(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd3,  1'b1, 1'b0, 2'd0, 4'd0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 4'd4,  1'b1, 1'b0, 2'd0, 4'd0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 4'd9,  1'b1, 1'b1, 2'd2, 4'd9, 0, 1, 1'b0};
    tbl[3] = '{1'b1, 4'd9,  1'b1, 1'b0, 2'd0, 4'd0, 0, 1, 1'b0};
    tbl[4] = '{1'b1, 4'd10, 1'b1, 1'b0, 2'd0, 4'd0, 0, 1, 1'b0};

    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_type", 32'(out_type), 0);
    chk("rst_val", 32'(out_val), 0);
    chk("rst_wrap", 32'(wrap_cnt), 0);
    chk("rst_skip", 32'(skip_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 0..15,0,1: a single wrap on the 17th sample
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 4'(i % 16), 1'b0);
      chk($sformatf("seq_valid%0d", i),
          32'(out_valid), (i >= 16) ? 1 : 0);
    end
    chk("seq_type", 32'(out_type), 1);
    chk("seq_val", 32'(out_val), 0);
    chk("seq_wrap", 32'(wrap_cnt), 1);
    chk("seq_skip", 32'(skip_cnt), 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i),
          32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_type", i),
            32'(out_type), 32'(tbl[i].et));
        chk($sformatf("tbl%0d_val", i),
            32'(out_val), 32'(tbl[i].ed));
      end
      chk($sformatf("tbl%0d_wrap", i),
          32'(wrap_cnt), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_skip", i),
          32'(skip_cnt), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_ovf", i),
          32'(overflow), 32'(tbl[i].eo));
    end

    // six skips into a 4-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i % 2) ? 4'd5 : 4'd0, 1'b0);
      chk($sformatf("ovf_flag%0d", i),
          32'(overflow), (i >= 5) ? 1 : 0);
    end
    chk("ovf_skip", 32'(skip_cnt), 6);
    step(1'b0, 4'h0, 1'b0);
    chk("ovf_hold_val", 32'(out_val), 5);
    drain(4'd5, "ovf_d0");
    drain(4'd0, "ovf_d1");
    drain(4'd5, "ovf_d2");
    drain(4'd0, "ovf_d3");
    chk("ovf_empty", 32'(out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // full FIFO, next skip arrives with a pop
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b1, (i % 2) ? 4'd5 : 4'd0, 1'b0);
    chk("full_ovf0", 32'(overflow), 0);
    step(1'b1, 4'd5, 1'b1);
    chk("full_ovf1", 32'(overflow), 0);
    chk("full_skip", 32'(skip_cnt), 5);
    drain(4'd0, "full_d0");
    drain(4'd5, "full_d1");
    drain(4'd0, "full_d2");
    drain(4'd5, "full_d3");
    chk("full_empty", 32'(out_valid), 0);

    // five wraps, four skips; narrow totals saturate
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, (i % 2) ? 4'd0 : 4'hF, 1'b0);
    chk("sat_wrap2", 32'(s_wrap), 3);
    chk("sat_skip2", 32'(s_skip), 3);
    chk("sat_wrap8", 32'(wrap_cnt), 5);
    chk("sat_skip8", 32'(skip_cnt), 4);
    chk("sat_ovf", 32'(overflow), 1);

    // reset with two records pending
    do_reset();
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    chk("mid_pre", 32'(out_valid), 1);
    do_reset();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_skip0", 32'(skip_cnt), 0);
    step(1'b1, 4'd7, 1'b0);
    chk("mid_first", 32'(out_valid), 0);
    step(1'b1, 4'd2, 1'b0);
    chk("mid_ev_valid", 32'(out_valid), 1);
    chk("mid_ev_type", 32'(out_type), 2);
    chk("mid_ev_val", 32'(out_val), 2);
    chk("mid_skip1", 32'(skip_cnt), 1);
    step(1'b0, 4'h0, 1'b1);
    chk("mid_single", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
